ex_mult_unit: RTL and testbench

- Iterative integer multiplier in the EX stage.
- Consumes operands, destination register and RegWrite from the ID/EX pipe register when EX_ALUResult selects the multiply path.
- Computes MUL (low product half) or UMULH (high product half, unsigned) over several cycles.
- Asserts a stall that freezes PC, IF/ID and ID/EX until the result is presented to EX/MEM.

---
 rtl/ex_mult_unit_if.sv | 28 ++
 rtl/ex_mult_unit.sv | 107 ++++++++++
 tb/tb_ex_mult_unit.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/ex_mult_unit_if.sv
// Bundle of the EX-stage multiplier's pipeline-facing signals.
// The master side sits in the EX stage and the slave side is the multiplier.
interface ex_mult_unit_if #(
    parameter int WIDTH = 64
);
    logic             start;
    logic             op_hi;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [4:0]       rd_in;
    logic             regwrite_in;
    logic             flush;
    logic             stall;
    logic             done;
    logic [WIDTH-1:0] result;
    logic [4:0]       rd_out;
    logic             regwrite_out;

    modport master (
        output start, op_hi, a, b, rd_in, regwrite_in, flush,
        input  stall, done, result, rd_out, regwrite_out
    );

    modport slave (
        input  start, op_hi, a, b, rd_in, regwrite_in, flush,
        output stall, done, result, rd_out, regwrite_out
    );
endinterface

// File: rtl/ex_mult_unit.sv
// Iterative unsigned multiplier for the EX stage. It retires STEP multiplier
// bits per cycle and stalls the front of the pipe until the product is presented.
module ex_mult_unit #(
    parameter int WIDTH = 64,
    parameter int STEP  = 2
) (
    input logic           clk,
    input logic           reset,
    ex_mult_unit_if.slave bus
);
    localparam int ITERS = WIDTH / STEP;
    localparam int CNT_W = $clog2(ITERS + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]         state;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [CNT_W-1:0]   cnt;
    logic               op_hi_q;
    logic [4:0]         rd_q;
    logic               rw_q;
    logic [WIDTH-1:0]   result_q;
    logic [4:0]         rd_out_q;

    logic [2*WIDTH-1:0] pp;
    logic [2*WIDTH-1:0] acc_next;
    logic               last_iter;

    // The multiplicand is kept pre-shifted by STEP*iteration, so each partial
    // product only needs the small per-bit shifts below.
    always_comb begin
        pp = '0;
        for (int unsigned j = 0; j < STEP; j++) begin
            if (mplier[j]) begin
                pp = pp + (mcand << j);
            end
        end
        acc_next  = acc + pp;
        last_iter = (cnt == CNT_W'(1));
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            cnt      <= '0;
            op_hi_q  <= 1'b0;
            rd_q     <= '0;
            rw_q     <= 1'b0;
            result_q <= '0;
            rd_out_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start && !bus.flush) begin
                        acc     <= '0;
                        mcand   <= {{WIDTH{1'b0}}, bus.a};
                        mplier  <= bus.b;
                        cnt     <= CNT_W'(ITERS);
                        op_hi_q <= bus.op_hi;
                        rd_q    <= bus.rd_in;
                        rw_q    <= bus.regwrite_in;
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    if (bus.flush) begin
                        state <= IDLE;
                    end else begin
                        acc    <= acc_next;
                        mcand  <= mcand << STEP;
                        mplier <= mplier >> STEP;
                        cnt    <= cnt - CNT_W'(1);
                        // The result is registered on the way into DONE so it can
                        // hold its value once the done pulse is over.
                        if (last_iter) begin
                            result_q <= op_hi_q ? acc_next[2*WIDTH-1:WIDTH]
                                                : acc_next[WIDTH-1:0];
                            rd_out_q <= rd_q;
                            state    <= DONE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        bus.stall        = (state == IDLE) ? bus.start : (state == BUSY);
        bus.done         = (state == DONE);
        bus.regwrite_out = (state == DONE) && rw_q;
        bus.result       = result_q;
        bus.rd_out       = rd_out_q;
    end
endmodule

// File: tb/tb_ex_mult_unit.sv
// Self-checking bench for ex_mult_unit: directed table, randomized products
// against a 128-bit arithmetic model, and flush/reset/back-to-back sequences.
module tb_ex_mult_unit;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    ex_mult_unit_if #(.WIDTH(64)) ifc ();

    ex_mult_unit #(.WIDTH(64), .STEP(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        op_hi;
        logic [4:0]  rd;
        logic        rw;
        bit          scramble;
        logic [63:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [63:0] x, input logic [63:0] y, input logic hi);
        logic [127:0] p;
        p = {64'd0, x} * {64'd0, y};
        return hi ? p[127:64] : p[63:0];
    endfunction

    // Called at posedge+1 in IDLE; returns at posedge+2 one cycle after done.
    task automatic do_op(input logic [63:0] ta, input logic [63:0] tb_v, input logic top,
                         input logic [4:0] trd, input logic trw, input bit hold,
                         input bit scramble, input logic [63:0] exp, input string tag);
        int stalls;
        bit seen;
        stalls = 0;
        seen   = 0;
        ifc.start       = 1'b1;
        ifc.a           = ta;
        ifc.b           = tb_v;
        ifc.op_hi       = top;
        ifc.rd_in       = trd;
        ifc.regwrite_in = trw;
        #1;
        for (int c = 0; c < 45 && !seen; c++) begin
            if (ifc.done) begin
                seen = 1;
            end else begin
                if (ifc.stall) stalls++;
                @(posedge clk);
                #1;
                if (!hold) ifc.start = 1'b0;
                if (scramble) begin
                    ifc.a           = {$urandom, $urandom};
                    ifc.b           = {$urandom, $urandom};
                    ifc.op_hi       = ~top;
                    ifc.rd_in       = 5'($urandom);
                    ifc.regwrite_in = ~trw;
                end
                #1;
            end
        end
        check({tag, " done seen"}, 128'(seen), 128'd1);
        check({tag, " stall cycles"}, 128'(stalls), 128'd33);
        check({tag, " stall in done"}, 128'(ifc.stall), 128'd0);
        check({tag, " result"}, 128'(ifc.result), 128'(exp));
        check({tag, " rd_out"}, 128'(ifc.rd_out), 128'(trd));
        check({tag, " regwrite_out"}, 128'(ifc.regwrite_out), 128'(trw));
        @(posedge clk);
        #1;
        check({tag, " done after"}, 128'(ifc.done), 128'd0);
        check({tag, " regwrite after"}, 128'(ifc.regwrite_out), 128'd0);
        check({tag, " result hold"}, 128'(ifc.result), 128'(exp));
        if (hold) check({tag, " re-accept stall"}, 128'(ifc.stall), 128'd1);
        #1;
    endtask

    vec_t vecs[6];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int dones;
        logic [63:0] ra, rb;
        logic        rh;

        vecs[0] = '{64'd3, 64'd5, 1'b0, 5'd7, 1'b1, 1'b0, 64'd15};
        vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b0, 5'd1, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE};
        vecs[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b1, 5'd2, 1'b0, 1'b0, 64'h1};
        vecs[3] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 5'd30, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE};
        vecs[4] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 5'd31, 1'b1, 1'b0, 64'h1};
        vecs[5] = '{64'd0, 64'h1234, 1'b0, 5'd9, 1'b1, 1'b1, 64'd0};

        reset = 1'b0;
        ifc.start = 1'b0; ifc.op_hi = 1'b0; ifc.a = '0; ifc.b = '0;
        ifc.rd_in = '0; ifc.regwrite_in = 1'b0; ifc.flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset stall", 128'(ifc.stall), 128'd0);
        check("reset done", 128'(ifc.done), 128'd0);
        check("reset result", 128'(ifc.result), 128'd0);
        check("reset rd_out", 128'(ifc.rd_out), 128'd0);
        check("reset regwrite", 128'(ifc.regwrite_out), 128'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 6; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].op_hi, vecs[i].rd, vecs[i].rw, 1'b0,
                  vecs[i].scramble, vecs[i].exp, $sformatf("vec%0d", i));
        end

        for (int i = 0; i < 8; i++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            rh = 1'($urandom);
            do_op(ra, rb, rh, 5'($urandom), 1'($urandom), 1'b0, 1'(i % 2),
                  model(ra, rb, rh), $sformatf("rand%0d", i));
        end

        // start together with flush is refused
        ifc.start = 1'b1; ifc.flush = 1'b1; ifc.a = 64'd4; ifc.b = 64'd4;
        @(posedge clk);
        #1;
        ifc.start = 1'b0; ifc.flush = 1'b0;
        #1;
        check("start+flush not accepted", 128'(ifc.stall), 128'd0);

        // flush in BUSY cycle 10
        ifc.start = 1'b1; ifc.a = 64'd9; ifc.b = 64'd9; ifc.op_hi = 1'b0;
        ifc.rd_in = 5'd3; ifc.regwrite_in = 1'b1;
        @(posedge clk);
        #1;
        ifc.start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        ifc.flush = 1'b1;
        #1;
        check("flush cycle stall", 128'(ifc.stall), 128'd1);
        @(posedge clk);
        #1;
        ifc.flush = 1'b0;
        #1;
        check("post-flush stall", 128'(ifc.stall), 128'd0);
        dones = 0;
        for (int c = 0; c < 40; c++) begin
            if (ifc.done || ifc.regwrite_out) dones++;
            @(posedge clk);
            #1;
        end
        check("no done after flush", 128'(dones), 128'd0);
        #1;
        do_op(64'd6, 64'd7, 1'b0, 5'd12, 1'b1, 1'b0, 1'b0, 64'd42, "after flush");

        // reset in BUSY cycle 5
        ifc.start = 1'b1; ifc.a = 64'd100; ifc.b = 64'd100; ifc.rd_in = 5'd20;
        @(posedge clk);
        #1;
        ifc.start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #2;
        check("midreset stall", 128'(ifc.stall), 128'd0);
        check("midreset done", 128'(ifc.done), 128'd0);
        check("midreset result", 128'(ifc.result), 128'd0);
        check("midreset rd_out", 128'(ifc.rd_out), 128'd0);
        check("midreset regwrite", 128'(ifc.regwrite_out), 128'd0);
        reset = 1'b1;
        dones = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (ifc.done) dones++;
        end
        check("no done after reset", 128'(dones), 128'd0);

        // start held high: back-to-back operations
        do_op(64'd11, 64'd13, 1'b0, 5'd4, 1'b1, 1'b1, 1'b0, 64'd143, "hold0");
        do_op(64'hDEAD_BEEF_0000_0001, 64'h1_0000_0000, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0,
              model(64'hDEAD_BEEF_0000_0001, 64'h1_0000_0000, 1'b1), "hold1");
        ifc.start = 1'b0;
        repeat (40) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
